// File: rtl/lsu_unit_if.sv
// Request/response and memory-port bundle for lsu_unit.
// slave = the load/store unit, master = the core/memory side driving it.
interface lsu_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [2:0]          req_func3;
    logic [ADDR_W-1:0]   req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_rdata;
    logic                rsp_err;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN/8-1:0]   mem_wmask;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_rvalid;
    logic [XLEN-1:0]     mem_rdata;

    modport slave (
        input  req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
               mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
               mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/lsu_unit.sv
// Multicycle load/store unit: IDLE -> WAIT (mem req/ack, timeout) -> RESP.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module lsu_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    lsu_unit_if.slave  bus
);
    localparam int MASK_W = XLEN / 8;
    localparam int OFF_W  = $clog2(MASK_W);
    localparam int CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [OFF_W-1:0]   lat_off;
    logic [1:0]         lat_size;
    logic               lat_uns;
    logic               lat_write;

    logic [1:0]         size;
    logic [OFF_W-1:0]   off, size_mask, off_use;
    logic               illegal, trap, tmo;
    logic [MASK_W-1:0]  wmask;
    logic [XLEN-1:0]    shifted, ld_fmt;

    logic               rsp_err_q, mem_req_q, mem_we_q;
    logic [XLEN-1:0]    rsp_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [MASK_W-1:0]  mem_wmask_q;

    // Request decode: lane offset, fault detection and byte-enable mask.
    always_comb begin
        size      = bus.req_func3[1:0];
        off       = bus.req_addr[OFF_W-1:0];
        size_mask = OFF_W'((32'd1 << size) - 32'd1);
        illegal   = (XLEN == 32) && (size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        off_use   = off;
        trap      = illegal || ((off & size_mask) != '0);
`else
        off_use   = off & ~size_mask;
        trap      = illegal;
`endif
        wmask     = MASK_W'(((32'd1 << (32'd1 << size)) - 32'd1) << off_use);
    end

    // Load formatting from the latched request; sign-extend unless func3[2].
    always_comb begin
        tmo     = (cnt == CNT_W'(TIMEOUT - 1));
        shifted = bus.mem_rdata >> {lat_off, 3'b000};
        ld_fmt  = shifted;
        case (lat_size)
            2'b00: begin
                if (lat_uns) ld_fmt = XLEN'(shifted[7:0]);
                else         ld_fmt = XLEN'($signed(shifted[7:0]));
            end
            2'b01: begin
                if (lat_uns) ld_fmt = XLEN'(shifted[15:0]);
                else         ld_fmt = XLEN'($signed(shifted[15:0]));
            end
            2'b10: begin
                if (lat_uns) ld_fmt = XLEN'(shifted[31:0]);
                else         ld_fmt = XLEN'($signed(shifted[31:0]));
            end
            default: ld_fmt = shifted;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = trap ? RESP : WAIT;
            WAIT:    if (bus.mem_rvalid || tmo) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            lat_off     <= '0;
            lat_size    <= '0;
            lat_uns     <= 1'b0;
            lat_write   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_req_q <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    lat_off   <= off_use;
                    lat_size  <= size;
                    lat_uns   <= bus.req_func3[2];
                    lat_write <= bus.req_write;
                    cnt       <= '0;
                    if (trap) begin
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.req_write;
                        mem_addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_wmask_q <= bus.req_write ? wmask : '0;
                        mem_wdata_q <= bus.req_wdata << {off_use, 3'b000};
                    end
                end
                WAIT: begin
                    // An ack on the timeout cycle still wins over the fault.
                    if (bus.mem_rvalid) begin
                        cnt         <= '0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= lat_write ? '0 : ld_fmt;
                    end else if (tmo) begin
                        cnt         <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: arithmetic reference model + per-cycle compare process,
// plus literal pins on the test-plan vectors. Honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_unit;
    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();
    lsu_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic        trap;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int total = 0;
    int bad   = 0;

    logic        m_active = 1'b0, m_memphase = 1'b0, m_write = 1'b0, m_tmo = 1'b0;
    logic [2:0]  m_f3 = 3'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_word = '0;
    logic [31:0] last_rdata, last_wdata, last_maddr;
    logic [3:0]  last_mask;
    logic        last_err;
    exp_t        ce;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // What a request must produce, computed from byte-lane arithmetic.
    function automatic exp_t model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] word, input logic tmo);
        exp_t e;
        int nb, off;
        logic [63:0] v, keep;
        nb  = 1 << f3[1:0];
        off = int'(a[1:0]);
        e.trap = (nb == 8);
`ifdef LSU_MISALIGN_TRAP_EN
        if (off % nb != 0) e.trap = 1'b1;
`endif
        off     = off - (off % nb);
        e.addr  = {a[31:2], 2'b00};
        e.we    = w;
        e.mask  = w ? 4'(((1 << nb) - 1) << off) : 4'b0;
        e.wdata = 32'({32'b0, wd} << (8 * off));
        keep    = (64'd1 << (8 * nb)) - 64'd1;
        v       = ({32'b0, word} >> (8 * off)) & keep;
        if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | ~keep;
        e.err   = e.trap || tmo;
        e.rdata = (w || e.err) ? 32'b0 : v[31:0];
        return e;
    endfunction

    // Compare process: responses and held memory-port fields every cycle they matter.
    always @(negedge clk) begin
        if (!rst) begin
            ce = model(m_write, m_f3, m_addr, m_wdata, m_word, m_tmo);
            if (bus.rsp_valid) begin
                chk("rsp_only_when_pending", 64'(m_active), 64'd1);
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(ce.rdata));
                chk("rsp_err", 64'(bus.rsp_err), 64'(ce.err));
                chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
            end
            if (m_memphase && !bus.rsp_valid) begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(ce.addr));
                chk("mem_we", 64'(bus.mem_we), 64'(ce.we));
                chk("mem_wmask", 64'(bus.mem_wmask), 64'(ce.mask));
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(ce.wdata));
            end
            if (bus.mem_req) chk("mem_req_legal", 64'(m_memphase), 64'd1);
        end
    end

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input logic tmo);
        m_write = w; m_f3 = f3; m_addr = a; m_wdata = wd; m_word = word; m_tmo = tmo;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_func3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        m_active = 1'b1;
    endtask

    // k = ack cycle after accept (0 = never), hold = extra RESP cycles with rsp_ready low.
    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word,
                       input int k, input int hold, input int lat);
        int c, nreq;
        exp_t e;
        e = model(w, f3, a, wd, word, (k == 0 || k > TIMEOUT));
        issue(w, f3, a, wd, word, (k == 0 || k > TIMEOUT));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        m_memphase = !e.trap;
        nreq = 0;
        c = 1;
        while (c <= 40 && !bus.rsp_valid) begin
            if (c == 1) begin
                chk("mem_req_first_wait", 64'(bus.mem_req), 64'd1);
                last_mask = bus.mem_wmask; last_wdata = bus.mem_wdata; last_maddr = bus.mem_addr;
            end
            nreq += int'(bus.mem_req);
            bus.mem_rvalid = (c == k);
            bus.mem_rdata  = (c == k) ? word : 32'hBAD0_BAD0;
            @(posedge clk); #1;
            c++;
        end
        bus.mem_rvalid = 1'b0;
        m_memphase = 1'b0;
        chk("latency", 64'(c), 64'(lat));
        chk("mem_req_count", 64'(nreq), e.trap ? 64'd0 : 64'd1);
        last_rdata = bus.rsp_rdata;
        last_err   = bus.rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_rdata", 64'(bus.rsp_rdata), 64'(last_rdata));
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        m_active = 1'b0;
        chk("handoff_valid", 64'(bus.rsp_valid), 64'd0);
        chk("handoff_ready", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
        chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        chk({tag, "_mem_req"},   64'(bus.mem_req),   64'd0);
        chk({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
        chk({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
        chk({tag, "_mem_wmask"}, 64'(bus.mem_wmask), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_func3 = 3'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Signed byte load, ack at k=1.
        txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 1, 0, 2);
        chk("lb_rdata_lit", 64'(last_rdata), 64'hFFFF_FF80);
        chk("lb_err_lit", 64'(last_err), 64'd0);
        chk("lb_addr_lit", 64'(last_maddr), 64'h8000_0000);

        // Halfword store.
        txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'h0, 2, 0, 3);
        chk("sh_mask_lit", 64'(last_mask), 64'b1100);
        chk("sh_wdata_lit", 64'(last_wdata), 64'h1234_0000);
        chk("sh_rdata_lit", 64'(last_rdata), 64'd0);

        // Misaligned unsigned halfword.
`ifdef LSU_MISALIGN_TRAP_EN
        txn(1'b0, 3'b101, 32'h8000_0001, 32'h0, 32'h1234_5678, 1, 0, 1);
        chk("lhu_trap_err_lit", 64'(last_err), 64'd1);
        chk("lhu_trap_rdata_lit", 64'(last_rdata), 64'd0);
`else
        txn(1'b0, 3'b101, 32'h8000_0001, 32'h0, 32'h1234_5678, 1, 0, 2);
        chk("lhu_align_rdata_lit", 64'(last_rdata), 64'h0000_5678);
        chk("lhu_align_err_lit", 64'(last_err), 64'd0);
`endif

        // Timeout, then stale acks in IDLE.
        txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 0, 0, 5);
        chk("tmo_err_lit", 64'(last_err), 64'd1);
        chk("tmo_rdata_lit", 64'(last_rdata), 64'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_5555;
        repeat (2) begin
            @(posedge clk); #1;
            chk("stale_no_rsp", 64'(bus.rsp_valid), 64'd0);
            chk("stale_ready", 64'(bus.req_ready), 64'd1);
        end
        bus.mem_rvalid = 1'b0;

        // Ack on the timeout cycle wins.
        txn(1'b0, 3'b010, 32'h8000_0014, 32'h0, 32'hDEAD_BEEF, 4, 0, 5);
        chk("edge_ack_rdata_lit", 64'(last_rdata), 64'hDEAD_BEEF);
        chk("edge_ack_err_lit", 64'(last_err), 64'd0);

        // Backpressure on an unsigned byte load.
        txn(1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h1122_3344, 3, 5, 4);
        chk("lbu_rdata_lit", 64'(last_rdata), 64'h22);

        // Signed halfword, upper lane.
        txn(1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_0000, 1, 0, 2);
        chk("lh_rdata_lit", 64'(last_rdata), 64'hFFFF_8001);

        // Doubleword is illegal at XLEN=32.
        txn(1'b0, 3'b011, 32'h8000_0008, 32'h0, 32'h0, 1, 0, 1);
        chk("ld_err_lit", 64'(last_err), 64'd1);

        // Byte store at lane 1.
        txn(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0, 1, 0, 2);
        chk("sb_mask_lit", 64'(last_mask), 64'b0010);
        chk("sb_wdata_lit", 64'(last_wdata), 64'h0000_AB00);

        // Reset while in WAIT, then a late ack.
        issue(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h7777_7777, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        m_memphase = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        m_memphase = 1'b0;
        m_active = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_vals("post_reset");
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
        repeat (3) begin
            @(posedge clk); #1;
            chk("late_ack_no_rsp", 64'(bus.rsp_valid), 64'd0);
            chk("late_ack_ready", 64'(bus.req_ready), 64'd1);
        end
        bus.mem_rvalid = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_unit.md
# lsu_unit

Parametrised multicycle load/store unit for the NPC core. It sits between IDU/WBU and data memory, replacing the single-shot combinational memory access. It accepts one request per valid/ready handshake and drives a request/acknowledge memory port. It returns a formatted, sign- or zero-extended response with error reporting for bus timeout and, optionally, misalignment.

## Interface
Parameters:
- XLEN, 32: data width; legal values are 32 and 64.
- ADDR_W, 32: address width.
- TIMEOUT, 16: cycles spent in WAIT without `mem_rvalid` before an error response; legal values are ≥ 2.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3: [1:0] size (00 b, 01 h, 10 w, 11 d); [2] unsigned (loads only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and for errors.
- rsp_err  out  1  access fault (timeout, illegal size, or misalignment).
- mem_req  out  1  one-cycle memory request strobe.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are 0.
- mem_wmask  out  XLEN/8  byte-enable mask.
- mem_wdata  out  XLEN  store data shifted into lane position.
- mem_rvalid  in  1  memory acknowledge; carries read data for loads, completion for stores.
- mem_rdata  in  XLEN  memory word.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, the unit latches the request.
  - An illegal size (11 when XLEN = 32) goes to RESP with `rsp_err` = 1 and no `mem_req`.
  - Otherwise the unit goes to WAIT.
- WAIT:
  - `mem_req` is high in the first WAIT cycle only.
  - `mem_rvalid` is sampled in every WAIT cycle, including the first.
  - On `mem_rvalid`, a load captures and formats `mem_rdata`, then the unit goes to RESP with `rsp_err` = 0.
  - The timeout counter increments each WAIT cycle. When it reaches TIMEOUT with no `mem_rvalid`, the unit goes to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - If `mem_rvalid` arrives in the same cycle the counter reaches TIMEOUT, the data is taken and no error is reported.
- RESP:
  - `rsp_valid` = 1, and outputs stay stable until `rsp_ready`.
  - On `rsp_ready`, the unit goes to IDLE.
  - `req_ready` stays 0 in the handoff cycle; there is no bypass.
- Lane arithmetic:
  - off = `req_addr`[log2(XLEN/8)-1:0].
  - nbytes = 1 << size.
  - `mem_wmask` = ((1 << nbytes) - 1) << off, truncated to XLEN/8 bits. Loads drive `mem_wmask` = 0 and `mem_we` = 0.
  - `mem_wdata` = `req_wdata` << (8·off).
  - Load data = `mem_rdata` >> (8·off), truncated to nbytes. It is sign-extended from the top bit when func3[2] = 0 and zero-extended when func3[2] = 1.
- `mem_rvalid` is ignored in IDLE and RESP; stale acks must not corrupt state.
- `mem_addr`, `mem_we`, `mem_wmask` and `mem_wdata` are registered and held for the whole WAIT state.

## Timing
- Reset values:
  - State is IDLE.
  - `req_ready` = 1.
  - `rsp_valid`, `rsp_err`, `mem_req` and `mem_we` = 0.
  - `rsp_rdata`, `mem_addr`, `mem_wmask` and `mem_wdata` = 0.
  - The timeout counter is 0.
- A request accepted at edge N drives `mem_req` in cycle N+1.
- If `mem_rvalid` arrives in cycle N+k (k ≥ 1), `rsp_valid` rises in cycle N+k+1.
- Minimum accept-to-response latency is 2 cycles. An error with no memory access responds in 1 cycle.
- Maximum throughput is one request per 3 cycles (IDLE, WAIT, RESP).
- A timeout response appears TIMEOUT+1 cycles after acceptance.
- Reset during WAIT or RESP:
  - The transaction is dropped and no response is issued.
  - A late `mem_rvalid` is ignored.
  - `req_ready` = 1 on the first cycle after reset deasserts.

## Configuration
- With `LSU_MISALIGN_TRAP_EN` defined: a request whose off is not a multiple of nbytes completes in 1 cycle (IDLE→RESP) with `rsp_err` = 1 and `rsp_rdata` = 0. No `mem_req` is issued.
- Without it: misalignment is not checked. Off is forced down to a multiple of nbytes (low bits cleared) and the access proceeds as aligned. Accesses that would cross a word boundary never occur.

## Test plan
- Signed byte load: XLEN=32, lb at 0x8000_0003, `mem_rdata` = 0x80AA_BBCC acked at k=1 -> `mem_addr` = 0x8000_0000, `rsp_rdata` = 0xFFFF_FF80, `rsp_err` = 0, `rsp_valid` 2 cycles after accept.
- Halfword store: sh at 0x8000_0002 with `req_wdata` = 0x0000_1234 -> `mem_we` = 1, `mem_wmask` = 0b1100, `mem_wdata` = 0x1234_0000, `rsp_rdata` = 0.
- Misaligned unsigned halfword: lhu at 0x8000_0001.
  - With `LSU_MISALIGN_TRAP_EN` -> no `mem_req`, `rsp_err` = 1 one cycle after accept.
  - Without it, `mem_rdata` = 0x1234_5678 -> off forced to 0, `rsp_rdata` = 0x0000_5678.
- Timeout: TIMEOUT=4, lw with `mem_rvalid` held 0 -> `rsp_valid` with `rsp_err` = 1, `rsp_rdata` = 0, five cycles after accept. A later `mem_rvalid` in IDLE is ignored.
- Backpressure: `rsp_ready` = 0 for 5 cycles in RESP -> `rsp_valid`/`rsp_rdata` stable and `req_ready` = 0 throughout. The next request is accepted only after `rsp_ready` is seen and the unit is back in IDLE.
- Reset mid-WAIT: assert `rst` in WAIT, then ack afterwards -> no `rsp_valid`, all outputs at reset values, `req_ready` = 1.
